// File: rtl/idct8_seq.sv
// idct8_seq: sequential 8-point 1-D inverse DCT.
// Loads eight Q(15-FRAC).FRAC coefficients, reconstructs eight signed 8-bit
// samples with one time-multiplexed MAC and a Q1.14 cosine ROM, then streams
// them out under a valid/ready handshake.
module idct8_seq #(
  parameter int FRAC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [7:0]  out_data,
  output logic               out_last,
  output logic               busy
);

  localparam logic signed [35:0] RND = 36'sd1 <<< (13 + FRAC);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]         r_kcnt;
  logic [5:0]         r_nk;
  logic [2:0]         r_ncnt;
  logic signed [35:0] r_acc_p0;
  logic signed [15:0] r_coef [8];
  logic signed [7:0]  r_obuf [8];

  logic [2:0]         w_k;
  logic [2:0]         w_n;
  logic signed [15:0] w_rom;
  logic signed [31:0] w_prod;
  logic signed [35:0] w_sum;

  // Cosine ROM: 8192*cos(m*pi/16) folded from the first quadrant, with the
  // DC column scaled by 1/sqrt(2). m = (2n+1)k taken modulo 32.
  function automatic logic signed [15:0] cos_rom(input logic [2:0] n,
                                                 input logic [2:0] k);
    logic [4:0]         m;
    logic [4:0]         idx;
    logic               neg;
    logic signed [15:0] mag;
    m   = {1'b0, n, 1'b1} * {2'b00, k};
    idx = m;
    neg = 1'b0;
    if (m > 5'd24) begin
      idx = 5'd0 - m;
    end else if (m > 5'd16) begin
      idx = m - 5'd16;
      neg = 1'b1;
    end else if (m > 5'd8) begin
      idx = 5'd16 - m;
      neg = 1'b1;
    end
    case (idx)
      5'd0:    mag = 16'sd8192;
      5'd1:    mag = 16'sd8035;
      5'd2:    mag = 16'sd7568;
      5'd3:    mag = 16'sd6811;
      5'd4:    mag = 16'sd5793;
      5'd5:    mag = 16'sd4551;
      5'd6:    mag = 16'sd3135;
      5'd7:    mag = 16'sd1598;
      default: mag = 16'sd0;
    endcase
    if (k == 3'd0) begin
      mag = 16'sd5793;
      neg = 1'b0;
    end
    return neg ? -mag : mag;
  endfunction

  // Round half up at the Q1.14 x Q.FRAC binary point, then clamp to int8.
  function automatic logic signed [7:0] round_sat(input logic signed [35:0] a);
    logic signed [35:0] r;
    r = (a + RND) >>> (14 + FRAC);
    if (r > 36'sd127) begin
      return 8'sd127;
    end else if (r < -36'sd128) begin
      return -8'sd128;
    end
    return 8'(r);
  endfunction

  assign w_k    = r_nk[2:0];
  assign w_n    = r_nk[5:3];
  assign w_rom  = cos_rom(w_n, w_k);
  assign w_prod = 32'(r_coef[w_k]) * 32'(w_rom);
  assign w_sum  = r_acc_p0 + 36'(w_prod);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake outputs, all derived from state.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'sd0;
    out_last    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (r_kcnt == 3'd7)) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_nk == 6'd63) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = r_obuf[r_ncnt];
        out_last  = (r_ncnt == 3'd7);
        if (out_ready && (r_ncnt == 3'd7)) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Control counters and accumulator; all wrap naturally back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_kcnt   <= 3'd0;
      r_nk     <= 6'd0;
      r_ncnt   <= 3'd0;
      r_acc_p0 <= 36'sd0;
    end else begin
      case (r_state)
        S_LOAD: if (in_valid) r_kcnt <= r_kcnt + 3'd1;
        S_CALC: begin
          r_nk     <= r_nk + 6'd1;
          r_acc_p0 <= (w_k == 3'd7) ? 36'sd0 : w_sum;
        end
        S_OUT:  if (out_ready) r_ncnt <= r_ncnt + 3'd1;
        default: ;
      endcase
    end
  end

  // Stage p0 -> storage: coefficient capture and finished-sample write-back.
  always_ff @(posedge clk) begin
    if ((r_state == S_LOAD) && in_valid) begin
      r_coef[r_kcnt] <= in_data;
    end
    if ((r_state == S_CALC) && (w_k == 3'd7)) begin
      r_obuf[w_n] <= round_sat(w_sum);
    end
  end

endmodule

// File: tb/tb_idct8_seq.sv
// Self-checking bench for idct8_seq: real-valued cosine reference model,
// negedge scoreboard, random input gaps and output backpressure.
module tb_idct8_seq;

  localparam int  FRAC = 4;
  localparam real PI   = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               out_last;
  logic               busy;

  idct8_seq #(.FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_pct = 100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ROM straight from the cosine definition.
  function automatic int rom_m(input int n, input int k);
    real c, v;
    c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v = 16384.0 * c / 2.0 * $cos(real'((2 * n + 1) * k) * PI / 16.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int idct_m(input int x[8], input int n);
    longint s;
    s = 0;
    for (int k = 0; k < 8; k++) s += longint'(x[k]) * longint'(rom_m(n, k));
    s = (s + (longint'(1) <<< (13 + FRAC))) >>> (14 + FRAC);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return int'(s);
  endfunction

  // Scoreboard state.
  int                sb_coef[8];
  int                sb_k = 0;
  int                sb_n = 0;
  int                exp_q[$];
  bit                prev_stall = 0;
  logic signed [7:0] prev_data;
  logic              prev_last;
  bit                lat_pending = 0;
  bit                want_ready = 0;
  int                t_last = 0;

  // Compare process: everything is sampled mid-cycle; a handshake seen here
  // completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_k = 0; sb_n = 0; exp_q.delete();
      prev_stall = 0; lat_pending = 0; want_ready = 0;
    end else begin
      check("busy_vs_in_ready", busy, !in_ready);
      if (want_ready) begin
        check("in_ready_after_last", in_ready, 1);
        want_ready = 0;
      end
      if (prev_stall && !out_valid) check("stall_valid_dropped", out_valid, 1);
      if (out_valid) begin
        if (in_ready) check("ready_and_valid_overlap", in_ready, 0);
        if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 0);
        if (prev_stall) begin
          check("stall_data_stable", out_data, prev_data);
          check("stall_last_stable", out_last, prev_last);
        end
        if (lat_pending) begin
          check("first_valid_latency", cyc - t_last, 64);
          lat_pending = 0;
        end
        if (out_ready && exp_q.size() > 0) begin
          check("out_data", out_data, exp_q.pop_front());
          check("out_last", out_last, (sb_n == 7));
          if (sb_n == 7) want_ready = 1;
          sb_n = (sb_n + 1) % 8;
        end
        prev_stall = !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end else begin
        prev_stall = 0;
      end
      if (in_valid && in_ready) begin
        sb_coef[sb_k] = int'(in_data);
        sb_k++;
        if (sb_k == 8) begin
          for (int n = 0; n < 8; n++) exp_q.push_back(idct_m(sb_coef, n));
          sb_k = 0;
          t_last = cyc + 1;
          lat_pending = 1;
        end
      end
    end
  end

  // Output backpressure driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (ready_pct >= 100) || ($urandom_range(99) < ready_pct);
    end
  end

  task automatic send_block(input int x[8], input int beats, input int gap_pct);
    int guard;
    for (int k = 0; k < beats; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = 16'(x[k]);
      guard = 0;
      while (!in_ready && guard < 3000) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 3000) check("in_ready_timeout", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !in_ready) && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 5000) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic reset_and_check(input string tag);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
  endtask

  task automatic rand_block(output int x[8]);
    int mode;
    mode = $urandom_range(3);
    for (int k = 0; k < 8; k++) begin
      if (mode == 0) x[k] = $signed(16'($urandom));
      else x[k] = int'($urandom_range(1200)) - 600;
    end
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int x[8];
    int g;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'sd0;
    repeat (3) @(posedge clk); #1;
    reset_and_check("reset");

    // Pin the reference model with hand-computed values.
    check("rom_n0_k0", rom_m(0, 0), 5793);
    check("rom_n5_k0", rom_m(5, 0), 5793);
    check("rom_n0_k1", rom_m(0, 1), 8035);
    check("rom_n7_k1", rom_m(7, 1), -8035);
    check("rom_n0_k4", rom_m(0, 4), 5793);
    x = '{362, 0, 0, 0, 0, 0, 0, 0};
    check("model_dc", idct_m(x, 3), 8);
    x = '{0, 256, 0, 0, 0, 0, 0, 0};
    check("model_ac_x0", idct_m(x, 0), 8);
    check("model_ac_x7", idct_m(x, 7), -8);
    x = '{32767, 0, 0, 0, 0, 0, 0, 0};
    check("model_sat_pos", idct_m(x, 4), 127);
    x = '{-32768, 0, 0, 0, 0, 0, 0, 0};
    check("model_sat_neg", idct_m(x, 4), -128);

    // Directed blocks.
    x = '{362, 0, 0, 0, 0, 0, 0, 0};     send_block(x, 8, 0); drain();
    x = '{0, 256, 0, 0, 0, 0, 0, 0};     send_block(x, 8, 0); drain();
    x = '{32767, 0, 0, 0, 0, 0, 0, 0};   send_block(x, 8, 0); drain();
    x = '{-32768, 0, 0, 0, 0, 0, 0, 0};  send_block(x, 8, 0); drain();
    x = '{0, 0, 0, 0, 0, 0, 0, 0};       send_block(x, 8, 0); drain();

    // Handshake stress with gaps and backpressure.
    ready_pct = 50;
    for (int b = 0; b < 20; b++) begin
      rand_block(x); send_block(x, 8, 30); drain();
    end
    ready_pct = 100;

    // Reset after five coefficients.
    rand_block(x); send_block(x, 5, 0);
    reset_and_check("rst_load");
    rand_block(x); send_block(x, 8, 0); drain();

    // Reset in CALC.
    rand_block(x); send_block(x, 8, 0);
    repeat (20) @(posedge clk); #1;
    check("calc_busy", busy, 1);
    reset_and_check("rst_calc");
    repeat (80) @(posedge clk); #1;
    rand_block(x); send_block(x, 8, 0); drain();

    // Reset in OUT after three samples have gone out.
    rand_block(x); send_block(x, 8, 0);
    g = 0;
    while (!out_valid && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("out_valid_reached", out_valid, 1);
    repeat (3) @(posedge clk); #1;
    reset_and_check("rst_out");
    repeat (20) @(posedge clk); #1;
    rand_block(x); send_block(x, 8, 0); drain();

    // Back-to-back blocks at full throughput.
    x = '{362, 100, -50, 20, 0, 0, 7, -3};  send_block(x, 8, 0);
    x = '{0, 256, 0, 0, 0, 0, 0, 0};        send_block(x, 8, 0);
    drain();

    // Random blocks, streamed; every tenth block gets gaps and stalls.
    for (int b = 0; b < 1000; b++) begin
      ready_pct = (b % 10 == 0) ? 60 : 100;
      rand_block(x);
      send_block(x, 8, (b % 10 == 0) ? 20 : 0);
    end
    ready_pct = 100;
    drain();
    repeat (4) @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idct8_seq.md
# idct8_seq

Sequential 8-point 1-D inverse DCT, the decode-side partner of the team's 8-point forward DCT datapath. Accepts eight signed fixed-point DCT coefficients X[0..7] in frequency order. Reconstructs eight signed 8-bit samples x[0..7] with a single time-multiplexed multiply-accumulate unit and a cosine ROM. Sits between the coefficient source (forward DCT output or a test feeder) and the 7-segment/LED display path on the board.

## Interface
- FRAC, 4, number of fractional bits in the input coefficient format (signed Q(15-FRAC).FRAC)
- clk  in  1  100 MHz system clock; all logic on its rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  coefficient beat valid
- in_ready  out  1  block can accept a coefficient; a beat transfers on in_valid && in_ready
- in_data  in  16  signed coefficient X[k], in order k = 0..7
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts sample; a beat transfers on out_valid && out_ready
- out_data  out  8  signed reconstructed sample x[n], in order n = 0..7
- out_last  out  1  high with out_valid on sample n = 7
- busy  out  1  high in CALC and OUT states

## Operation
- States: LOAD, CALC, OUT.
- LOAD:
  - in_ready = 1.
  - Each transfer writes coef[kcnt] and increments the 3-bit kcnt.
  - On the transfer with kcnt = 7, kcnt wraps to 0 and the block goes to CALC.
- CALC:
  - in_ready = 0; in_data and in_valid are ignored.
  - A 6-bit counter {n,k} runs 0..63, one MAC per cycle: acc += coef[k] * rom[n][k].
  - When k = 7, the final sum (including that product) is rounded, saturated and written to obuf[n], and acc clears.
  - After {n,k} = 63, the block goes to OUT.
- ROM:
  - 64 entries, signed 16-bit, Q1.14: rom[n][k] = round(16384 * c(k)/2 * cos((2n+1)kπ/16)).
  - c(0) = 1/√2, c(k>0) = 1.
  - Examples: rom[n][0] = 5793; rom[0][1] = 8035.
- Arithmetic:
  - Product is 32-bit signed; accumulator is 36-bit signed and never overflows.
  - Result = (acc + 2^(13+FRAC)) >>> (14+FRAC), i.e. round half up, arithmetic shift.
  - The result is saturated to [-128, 127] before being written to obuf.
- OUT:
  - out_valid = 1; out_data = obuf[ncnt]; out_last = (ncnt == 7).
  - Each output transfer increments ncnt.
  - On the transfer with ncnt = 7, the block returns to LOAD with all counters at 0.
- busy = 1 in CALC and OUT; 0 in LOAD.

## Timing
- Reset values (with rst_n = 0 at an edge):
  - State = LOAD; kcnt, {n,k}, ncnt and acc = 0.
  - in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, busy = 0.
  - obuf and coef need not be cleared.
- Input: one coefficient per cycle maximum; gaps (in_valid low) are allowed, and kcnt holds during gaps.
- Latency:
  - The last input transfer occurs at edge T.
  - CALC occupies cycles T+1..T+64.
  - out_valid rises after edge T+64 and is high in cycle T+65.
- Output backpressure: while out_valid && !out_ready, out_data and out_last hold stable and ncnt does not advance.
- Throughput: with out_ready held at 1, the eight outputs occupy consecutive cycles. in_ready returns high in the cycle after the out_last transfer.
- There is no overlap: a new block's coefficients are not accepted until OUT completes.
- Reset mid-operation: rst_n low in any state aborts at that edge.
  - Partial coefficients and results are discarded.
  - Outputs take their reset values.
  - No further out_valid occurs until a full new 8-beat load completes.
- Simultaneous events:
  - in_valid is ignored outside LOAD.
  - out_ready is ignored outside OUT.
  - rst_n has priority over all other inputs.

## Test plan
- DC only: X = {362, 0, 0, 0, 0, 0, 0, 0} (FRAC = 4) -> eight outputs all equal to 8, out_last on the 8th. First out_valid exactly 65 cycles after the 8th input transfer.
- First AC only: X = {0, 256, 0, 0, 0, 0, 0, 0} -> x[0] = 8 and x[7] = -8. All eight outputs bit-exact against a golden model using the same ROM and rounding rule.
- Saturation:
  - X0 = 32767, rest 0 -> all outputs 127.
  - X0 = -32768, rest 0 -> all outputs -128.
  - All-zero X -> all outputs 0.
- Handshake stress:
  - Random in_valid gaps on input -> correct kcnt behaviour.
  - Random out_ready on output -> out_data/out_last stable while stalled, no samples lost or duplicated.
  - Compare results against a golden model over 1000 random coefficient blocks.
- Reset mid-operation:
  - Assert rst_n = 0 after 5 loaded coefficients, then in CALC, then at ncnt = 3 in OUT.
  - Each time: the following cycle shows in_ready = 1, out_valid = 0, busy = 0.
  - The next full block produces correct results.
- Back-to-back blocks: two blocks streamed with out_ready = 1 -> in_ready high the cycle after the first block's out_last. Second block's results independent of the first (acc cleared).
